// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared sample type, widths, state encoding and bit-reverse helper
package fft_reorder_pkg;
  localparam int DW = 16;
  localparam int FW = DW - 1;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } Cplx;
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < width; i++) r[i] = value[width-1-i];
    return r;
  endfunction
endpackage

// File: rtl/reorder_sdpram.sv
// reorder_sdpram: simple dual-port sample RAM, enable-gated write, registered read with clearable read register
module reorder_sdpram
  import fft_reorder_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  Cplx           wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output Cplx           rdata
);
  Cplx mem [2**AW];
  // write port; contents are never cleared
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // read register doubles as the block's output register, so it resets to zero
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversed to natural-order ping-pong reorder buffer; FFT_REORDER_FFTSHIFT_EN selects DC-centred output order
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int STG = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  Cplx              in,
  input  logic             in_sync,
  output Cplx              out,
  output logic             out_valid,
  output logic             out_sync,
  output logic [2*STG-1:0] out_idx
);
  localparam int AW = 2*STG;
  state_t state, state_nx;
  logic [AW-1:0] wcnt, rcnt, wpos, rbin;
  logic wb, resync, wlast, we, re;
  assign resync = in_sync && (wcnt != '0);
  assign wlast  = &wcnt;
  assign we     = en && (state != IDLE || in_sync);
  assign re     = en && state == STREAM && !resync;
  assign wpos   = resync ? '0 : AW'(bitrev(32'(wcnt), AW));
`ifdef FFT_REORDER_FFTSHIFT_EN
  assign rbin = {~rcnt[AW-1], rcnt[AW-2:0]};
`else
  assign rbin = rcnt;
`endif
  // a mid-frame sync restarts filling; otherwise leave IDLE on sync and start streaming once a frame is complete
  always_comb begin
    state_nx = resync ? FILL
             : (state == IDLE && in_sync) ? FILL
             : (state == FILL && wlast) ? STREAM
             : state;
  end
  // state, write/read counters and bank select, all frozen while en is low
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      rcnt  <= '0;
      wb    <= 1'b0;
    end else if (en) begin
      state <= state_nx;
      if (we) wcnt <= resync ? AW'(1) : wcnt + 1'b1;
      if (state != IDLE && wlast && !resync) wb <= ~wb;
      rcnt  <= (state == STREAM && !resync) ? rcnt + 1'b1 : '0;
    end
  // output qualifiers line up with the RAM read register
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out_idx   <= '0;
    end else if (en) begin
      out_valid <= re;
      out_sync  <= re && rcnt == '0;
      if (re) out_idx <= rbin;
    end
  reorder_sdpram #(.AW(AW + 1)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({wb, wpos}),
    .wdata (in),
    .re    (re),
    .raddr ({~wb, rbin}),
    .rdata (out)
  );
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: table-driven ramp plus model-checked directed and random streams
module tb_fft_reorder;
  import fft_reorder_pkg::*;
  localparam int LEN = 16;
  localparam int AW = 4;
  typedef struct packed {
    logic          v;
    logic          s;
    logic [AW-1:0] idx;
    Cplx           d;
  } obs_t;
  typedef struct {
    logic          s;
    logic [15:0]   re;
    obs_t          want;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, in_sync = 1'b0;
  logic out_valid, out_sync;
  logic [AW-1:0] out_idx;
  Cplx din = '0, dout;
  int errors = 0, checks = 0;
  obs_t cur = '0;
  obs_t exp_q [int];
  Cplx frame [LEN];
  int pos = 0, es = 0, es0 = 0, lat = 0;
  bit active = 1'b0;
  logic e, s, r;
  vec_t tbl [33];

  fft_reorder #(.STG(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (din),
    .in_sync   (in_sync),
    .out       (dout),
    .out_valid (out_valid),
    .out_sync  (out_sync),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  function automatic int rev(input int p);
    int q = 0;
    for (int b = 0; b < AW; b++) q = q * 2 + ((p >> b) & 1);
    return q;
  endfunction

  function automatic int ord(input int i);
`ifdef FFT_REORDER_FFTSHIFT_EN
    return (i + LEN / 2) % LEN;
`else
    return i;
`endif
  endfunction

  function automatic obs_t observe();
    return {out_valid, out_sync, out_idx, dout};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got v=%0b s=%0b idx=%0d re=%0d im=%0d, want v=%0b s=%0b idx=%0d re=%0d im=%0d",
               name, es, got.v, got.s, got.idx, got.d.re, got.d.im, want.v, want.s, want.idx, want.d.re, want.d.im);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic model(input logic mr, input logic me, input logic ms, input Cplx d);
    if (mr) begin
      active = 1'b0;
      pos = 0;
      exp_q.delete();
      cur = '0;
    end else if (me) begin
      es++;
      if (ms) begin
        if (active && pos != 0) exp_q.delete();
        active = 1'b1;
        pos = 0;
      end
      if (active) begin
        frame[rev(pos)] = d;
        if (pos == LEN - 1)
          for (int i = 0; i < LEN; i++) exp_q[es + 1 + i] = {1'b1, i == 0, AW'(ord(i)), frame[ord(i)]};
        pos = (pos + 1) % LEN;
      end
      if (exp_q.exists(es)) begin
        cur = exp_q[es];
        exp_q.delete(es);
      end else begin
        cur.v = 1'b0;
        cur.s = 1'b0;
      end
    end
  endtask

  task automatic step(input logic se, input logic ss, input Cplx d, input logic sr = 1'b0);
    @(negedge clk);
    en = se;
    in_sync = ss;
    din = d;
    rst = sr;
    @(posedge clk);
    #1;
    model(sr, se, ss, d);
    check("model", observe(), cur);
  endtask

  task automatic ramp(input int im, input bit alt);
    for (int n = 0; n < LEN; n++) begin
      step(1'b1, n == 0, {16'(rev(n)), 16'(im)});
      if (n == 0) es0 = es;
      if (alt) step(1'b0, 1'b0, Cplx'($urandom));
    end
  endtask

  initial begin
    for (int n = 0; n < 33; n++) begin
      tbl[n].s = n == 0;
      tbl[n].re = n < 16 ? 16'(rev(n)) : n < 32 ? 16'(rev(n - 16) + 100) : 16'd0;
      tbl[n].want = n < 16 ? obs_t'(0)
                  : n < 32 ? {1'b1, n == 16, AW'(ord(n - 16)), 16'(ord(n - 16)), 16'd0}
                  : {1'b1, 1'b1, AW'(ord(0)), 16'(ord(0) + 100), 16'd0};
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b1, Cplx'($urandom), 1'b1);
    check("reset", observe(), '0);
    for (int n = 0; n < 33; n++) begin
      step(1'b1, tbl[n].s, {tbl[n].re, 16'd0});
      check("ramp_table", observe(), tbl[n].want);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    for (int f = 0; f < 3; f++) ramp(f, 1'b0);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0, Cplx'($urandom));
      if (k >= 1 && k < 33 && out_valid) lat++;
    end
    check_int("gapless_valid", lat, 32);
    step(1'b0, 1'b0, '0, 1'b1);
    ramp(0, 1'b1);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      e = k % 2 == 0;
      step(e, 1'b0, Cplx'($urandom));
      if (e && out_sync && lat < 0) lat = es - es0;
    end
    check_int("latency_en_toggle", lat, LEN);
    step(1'b0, 1'b0, '0, 1'b1);
    ramp(0, 1'b0);
    ramp(1, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b1, n == 0, {16'(rev(n)), 16'd2});
    check_int("stream_valid", out_valid, 1);
    step(1'b1, 1'b1, {16'd0, 16'd3});
    es0 = es;
    check_int("resync_drop", out_valid, 0);
    for (int n = 1; n < LEN; n++) step(1'b1, 1'b0, {16'(rev(n)), 16'd3});
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, Cplx'($urandom));
      if (out_sync && lat < 0) lat = es - es0;
    end
    check_int("resync_latency", lat, LEN);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, Cplx'($urandom));
    check_int("idle_quiet", int'(out_valid) + int'(dout != '0), 0);
    ramp(4, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, Cplx'($urandom));
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 399) == 0;
      e = $urandom_range(0, 3) != 0;
      s = $urandom_range(0, 29) == 0;
      step(e, s, Cplx'($urandom), r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
